// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests words from instruction memory,
// holds them for decode and follows branch redirects from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [3:0]  a1,
    output logic [3:0]  a2,
    output logic [3:0]  a3,
    output logic [15:0] r15,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic        redirect_pending;
    logic [31:0] target_q;
    logic        is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            instr            <= '0;
            instr_valid      <= 1'b0;
            redirect_pending <= 1'b0;
            target_q         <= '0;
            imem_req         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (branch_valid)
                        pc <= branch_target;
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    // The request stays up until acked; a redirect only
                    // takes effect once the in-flight word is returned.
                    if (imem_ack) begin
                        if (redirect_pending || branch_valid) begin
                            pc <= branch_valid ? branch_target : target_q;
                            redirect_pending <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (branch_valid) begin
                        redirect_pending <= 1'b1;
                        target_q         <= branch_target;
                    end
                end
                HOLD: begin
                    if (branch_valid) begin
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end else if (!stall) begin
                        pc          <= pc + 32'(PC_STEP);
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign r15       = pc[15:0] + 16'd8;
    assign is_store  = (instr[27:26] == 2'b01) && !instr[20];

    always_comb begin
        a1 = 4'h0;
        a2 = 4'h0;
        a3 = 4'h0;
        if (instr_valid) begin
            a1 = instr[19:16];
            a3 = instr[15:12];
            a2 = is_store ? instr[15:12] : instr[3:0];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequencing, stall, decode,
// redirects, wrap-around and reset during a fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  a1, a2, a3;
    logic [15:0] r15;
    logic [31:0] pc;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_valid(branch_valid),
        .branch_target(branch_target),
        .instr(instr), .instr_valid(instr_valid),
        .a1(a1), .a2(a2), .a3(a3), .r15(r15), .pc(pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout imem_req got %b exp 1", tag, imem_req);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0 ||
            instr !== 32'h0 || r15 !== 16'h8 ||
            a1 !== 4'h0 || a2 !== 4'h0 || a3 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state req=%b v=%b pc=%h instr=%h r15=%h exp 0,0,0,0,0008",
                     imem_req, instr_valid, pc, instr, r15);
        end
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req got %b exp 0", imem_req);
        end
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            wait_req("seq");
            exp_addr = 32'(i * 4);
            n_cmp++;
            if (imem_addr !== exp_addr || r15 !== exp_addr[15:0] + 16'd8) begin
                n_fail++;
                $display("FAIL seq_addr addr=%h r15=%h exp %h %h",
                         imem_addr, r15, exp_addr, exp_addr[15:0] + 16'd8);
            end
            fetch(32'hE1A0_0000 + 32'(i));
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== 32'hE1A0_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL seq_instr v=%b instr=%h exp 1 %h",
                         instr_valid, instr, 32'hE1A0_0000 + 32'(i));
            end
        end
        wait_req("seq_end");
    endtask

    task automatic test_stall;
        n_cmp++;
        if (imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_start addr=%h exp 00000010", imem_addr);
        end
        stall = 1'b1;
        fetch(32'hE081_2003);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || a1 !== 4'h1 || a2 !== 4'h3 ||
                a3 !== 4'h2 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold v=%b a1=%h a2=%h a3=%h req=%b exp 1 1 3 2 0",
                         instr_valid, a1, a2, a3, imem_req);
            end
            if (k == 1) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hFFFF_FFFF;
            end
            tick();
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
        n_cmp++;
        if (instr !== 32'hE081_2003 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL stray_ack instr=%h pc=%h exp e0812003 00000010", instr, pc);
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release req=%b addr=%h v=%b exp 1 00000014 0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_store;
        stall = 1'b1;
        fetch(32'hE581_2000);
        n_cmp++;
        if (a1 !== 4'h1 || a2 !== 4'h2 || a3 !== 4'h2) begin
            n_fail++;
            $display("FAIL store_decode a1=%h a2=%h a3=%h exp 1 2 2", a1, a2, a3);
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (imem_addr !== 32'h18 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL store_next addr=%h req=%b exp 00000018 1", imem_addr, imem_req);
        end
    endtask

    task automatic test_branch_req;
        branch_valid  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_valid = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h18) begin
            n_fail++;
            $display("FAIL br_pending req=%b addr=%h exp 1 00000018", imem_req, imem_addr);
        end
        tick();
        fetch(32'hDEAD_BEEF);
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL br_discard v=%b req=%b addr=%h exp 0 1 00000100",
                     instr_valid, imem_req, imem_addr);
        end
        stall = 1'b1;
        fetch(32'hE1A0_1111);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'hE1A0_1111) begin
            n_fail++;
            $display("FAIL br_refetch v=%b instr=%h exp 1 e1a01111", instr_valid, instr);
        end
    endtask

    task automatic test_branch_hold;
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_valid = 1'b0;
        stall        = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL br_hold v=%b req=%b addr=%h exp 0 1 00000200",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_latest_wins;
        branch_valid  = 1'b1;
        branch_target = 32'h300;
        tick();
        branch_target = 32'h400;
        tick();
        branch_valid = 1'b0;
        fetch(32'hDEAD_0000);
        n_cmp++;
        if (imem_addr !== 32'h400 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_latest addr=%h v=%b exp 00000400 0", imem_addr, instr_valid);
        end
    endtask

    task automatic test_wrap;
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        fetch(32'hDEAD_1111);
        branch_valid = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || r15 !== 16'h0004 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_start addr=%h r15=%h v=%b exp fffffffc 0004 0",
                     imem_addr, r15, instr_valid);
        end
        fetch(32'hE1A0_2222);
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_fetch v=%b exp 1", instr_valid);
        end
        tick();
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_next addr=%h req=%b exp 00000000 1", imem_addr, imem_req);
        end
    endtask

    task automatic test_reset_midfetch;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 ||
            r15 !== 16'h8 || a1 !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_async req=%b pc=%h v=%b r15=%h exp 0 0 0 0008",
                     imem_req, pc, instr_valid, r15);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_late_ack req=%b addr=%h v=%b exp 1 00000000 0",
                     imem_req, imem_addr, instr_valid);
        end
        rst_n = 1'b0;
        #1;
        rst_n         = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 32'h80;
        tick();
        branch_valid = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL idle_branch req=%b addr=%h exp 1 00000080", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        tick();
        test_reset();
        test_sequential();
        test_stall();
        test_store();
        test_branch_req();
        test_branch_hold();
        test_latest_wins();
        test_wrap();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
